fifo_pkt_drain: RTL and testbench
=================================

Name: fifo_pkt_drain

Overview:
Downstream consumer of the lab FIFO. It pops words from the FIFO's show-ahead read port (rd_data valid whenever empty==0; rd_en pops on the clock edge) and re-emits them on a valid/ready stream. Words are framed into fixed-length packets with sop/eop markers, and a programmable idle gap is inserted between packets. It also keeps a count of delivered words for status.

Parameters:
FIFO_WIDTH, 2, data width; matches the FIFO's FIFO_WIDTH.
PKT_LEN, 4, words per packet; must be >= 1.
GAP_CYCLES, 2, idle cycles forced after each eop word is loaded; 0 = no gap.
CNT_WIDTH, 16, width of the words_sent status counter.

Ports:
clk  in  1  clock; all state updates on posedge.
reset  in  1  asynchronous, active-low reset (0 = in reset).
enable  in  1  permits starting a new packet; sampled only in IDLE.
fifo_empty  in  1  FIFO empty flag.
fifo_rd_data  in  FIFO_WIDTH  FIFO head word; valid when fifo_empty==0.
fifo_rd_en  out  1  pop request to the FIFO; combinational.
out_valid  out  1  output word valid.
out_ready  in  1  sink accepts the word when out_valid && out_ready at posedge.
out_data  out  FIFO_WIDTH  output word.
out_sop  out  1  out_data is the first word of a packet.
out_eop  out  1  out_data is the last word of a packet.
busy  out  1  (state != IDLE) || out_valid.
words_sent  out  CNT_WIDTH  count of accepted output words; saturating.

Behaviour:
- Reset low, asynchronous:
  - state=IDLE; out_valid, out_data, out_sop, out_eop all 0; word_cnt=0; gap_cnt=0; words_sent=0.
  - fifo_rd_en is forced to 0 while reset==0.
- Reset release is synchronous-safe: outputs stay at reset values until the first posedge after deassertion. Reset mid-packet discards the partial packet; the next packet restarts at sop.
- Output-register space: space = !out_valid || out_ready.
- fifo_rd_en = reset && !fifo_empty && space && (state==STREAM || (state==IDLE && enable)). It is never asserted in GAP.
- On a pop at posedge:
  - out_data<=fifo_rd_data; out_valid<=1.
  - out_sop<=(word_cnt==0); out_eop<=(word_cnt==PKT_LEN-1).
  - word_cnt wraps to 0 after PKT_LEN-1, otherwise increments.
- No pop while out_valid && out_ready: out_valid<=0. Data and flags hold their last values.
- out_valid && !out_ready: out_data, out_sop and out_eop hold stable. No pop.
- Latency: one cycle from pop to out_valid. Throughput: 1 word/cycle inside a packet while out_ready==1 and the FIFO is non-empty.
- State transitions:
  - IDLE -> STREAM on a pop, when PKT_LEN>1.
  - STREAM -> GAP on the pop of the eop word when GAP_CYCLES>0, otherwise STREAM -> IDLE.
  - IDLE -> GAP/IDLE directly when PKT_LEN==1, by the same eop rule.
  - GAP: gap_cnt loads GAP_CYCLES-1 on entry. It counts down every cycle, independent of out_ready. At 0 -> IDLE.
- FIFO empties mid-packet: remain in STREAM and wait. This is not an error. out_valid drops once the last word is accepted.
- enable deasserted mid-packet: the packet completes normally. enable only gates the packet start in IDLE.
- words_sent increments on every out_valid && out_ready. It saturates at 2^CNT_WIDTH-1.
- busy has no combinational path from inputs.

Optional Feature:
- Macro FIFO_PKT_DRAIN_PARITY_EN.
- When defined:
  - Extra output port out_parity (1 bit) = even parity (XOR) of the word loaded into out_data.
  - It is registered alongside out_data, reset to 0, and held while stalled.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, enable=1, FIFO preloaded 0,1,2,3 (PKT_LEN=4, GAP_CYCLES=2), out_ready=1 -> out_data 0,1,2,3 on 4 consecutive cycles; sop with 0, eop with 3; then 2 cycles with fifo_rd_en=0; words_sent=4.
- Same load, out_ready=0 for 3 cycles after the first word -> out_data holds 0 with sop=1; no pops during the stall; the sequence resumes 1,2,3 without loss or duplication.
- Only 2 words (2,3) in FIFO, then 2 more (1,0) written 5 cycles later -> state stays STREAM; out_valid low during the starvation; 1 then 0 follow; eop on 0; the next word carries sop.
- enable=0 with FIFO non-empty -> fifo_rd_en=0, busy=0. Drop enable after the 2nd pop of a packet -> the packet still completes through eop, then no further pops.
- reset pulled low mid-packet (after 2 words) -> all outputs 0 immediately, without waiting for clk; after release, the next output word has sop=1 and words_sent restarts from 0.
- With FIFO_PKT_DRAIN_PARITY_EN, words 2'b11, 2'b01 -> out_parity 0 then 1. Without the macro: compiles with no out_parity port.

Source files
------------

// File: rtl/fifo_pkt_drain.sv
// Drains a show-ahead FIFO onto a valid/ready stream as fixed-length sop/eop packets, with an idle gap after each packet.
// Optional macro FIFO_PKT_DRAIN_PARITY_EN adds the out_parity output.
module fifo_pkt_drain #(
    parameter int FIFO_WIDTH = 2,
    parameter int PKT_LEN    = 4,
    parameter int GAP_CYCLES = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [FIFO_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [FIFO_WIDTH-1:0] out_data,
    output logic                  out_sop,
    output logic                  out_eop,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  words_sent
`ifdef FIFO_PKT_DRAIN_PARITY_EN
   ,output logic                  out_parity
`endif
);
    // state  | meaning
    // IDLE   | between packets; a pop here (enable=1) starts a packet
    // STREAM | inside a packet; pops continue regardless of enable
    // GAP    | forced idle after the eop word, gap_cnt counts down to 0

    localparam int WW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [WW-1:0] WORD_LAST = WW'(PKT_LEN - 1);
    localparam logic [GW-1:0] GAP_LOAD  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, STREAM, GAP} state_t;

    state_t          state;
    logic [WW-1:0]   word_cnt;
    logic [GW-1:0]   gap_cnt;
    logic            space;
    logic            pop;
    logic            last_word;

    assign space      = !out_valid || out_ready;
    assign pop        = reset && !fifo_empty && space &&
                        ((state == STREAM) || ((state == IDLE) && enable));
    assign fifo_rd_en = pop;
    assign last_word  = (word_cnt == WORD_LAST);
    assign busy       = (state != IDLE) || out_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            word_cnt   <= '0;
            gap_cnt    <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_sop    <= 1'b0;
            out_eop    <= 1'b0;
            words_sent <= '0;
`ifdef FIFO_PKT_DRAIN_PARITY_EN
            out_parity <= 1'b0;
`endif
        end else begin
            if (out_valid && out_ready && (words_sent != CNT_MAX))
                words_sent <= words_sent + CNT_WIDTH'(1);

            if (pop) begin
                out_data  <= fifo_rd_data;
                out_valid <= 1'b1;
                out_sop   <= (word_cnt == '0);
                out_eop   <= last_word;
`ifdef FIFO_PKT_DRAIN_PARITY_EN
                out_parity <= ^fifo_rd_data;
`endif
                if (last_word) begin
                    word_cnt <= '0;
                    if (GAP_CYCLES > 0) begin
                        state   <= GAP;
                        gap_cnt <= GAP_LOAD;
                    end else begin
                        state <= IDLE;
                    end
                end else begin
                    word_cnt <= word_cnt + WW'(1);
                    state    <= STREAM;
                end
            end else begin
                // Flags and data deliberately hold when the word drains.
                if (out_valid && out_ready)
                    out_valid <= 1'b0;
                if (state == GAP) begin
                    if (gap_cnt == '0)
                        state <= IDLE;
                    else
                        gap_cnt <= gap_cnt - GW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_pkt_drain.sv
// Self-checking bench for fifo_pkt_drain: directed table, hand sequences and a randomized run against a packet-level model.
module tb_fifo_pkt_drain;
    localparam int W    = 2;
    localparam int PL   = 4;
    localparam int GAP  = 2;
    localparam int CW   = 4;
    localparam int WMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          fifo_empty;
    logic [W-1:0]  fifo_rd_data;
    logic          fifo_rd_en;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_sop;
    logic          out_eop;
    logic          busy;
    logic [CW-1:0] words_sent;
`ifdef FIFO_PKT_DRAIN_PARITY_EN
    logic          out_parity;
`endif

    fifo_pkt_drain #(.FIFO_WIDTH(W), .PKT_LEN(PL), .GAP_CYCLES(GAP), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
        .busy(busy), .words_sent(words_sent)
`ifdef FIFO_PKT_DRAIN_PARITY_EN
       ,.out_parity(out_parity)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // FIFO contents and packet-level model of the stream
    logic [W-1:0] q[$];
    int           m_pos, m_gap, m_ws;
    logic         m_valid, m_sop, m_eop, m_par;
    logic [W-1:0] m_data;
    logic         last_pop;
    int           pops;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pos = 0; m_gap = 0; m_ws = 0;
        m_valid = 1'b0; m_sop = 1'b0; m_eop = 1'b0; m_par = 1'b0; m_data = '0;
    endtask

    task automatic drive_fifo();
        fifo_empty   = (q.size() == 0);
        fifo_rd_data = (q.size() > 0) ? q[0] : '0;
    endtask

    // One clock: drive at negedge, check pop before the edge, check outputs at next negedge.
    task automatic step(input logic en, input logic rdy);
        logic exp_pop;
        enable = en; out_ready = rdy; drive_fifo();
        #1;
        exp_pop = (q.size() > 0) && (!m_valid || rdy) && (m_gap == 0) && ((m_pos > 0) || en);
        chk("rd_en", 32'(fifo_rd_en), 32'(exp_pop));
        last_pop = fifo_rd_en;
        @(posedge clk);
        if (m_gap > 0) m_gap--;
        if (m_valid && rdy && m_ws < WMAX) m_ws++;
        if (last_pop) begin
            pops++;
            m_data  = (q.size() > 0) ? q.pop_front() : '0;
            m_sop   = (m_pos == 0);
            m_eop   = (m_pos == PL - 1);
            m_par   = ^m_data;
            m_valid = 1'b1;
            m_pos   = (m_pos + 1) % PL;
            if (m_eop) m_gap = GAP;
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
        chk("out_valid",  32'(out_valid),  32'(m_valid));
        chk("out_data",   32'(out_data),   32'(m_data));
        chk("out_sop",    32'(out_sop),    32'(m_sop));
        chk("out_eop",    32'(out_eop),    32'(m_eop));
        chk("busy",       32'(busy),       32'(m_valid || m_pos > 0 || m_gap > 0));
        chk("words_sent", 32'(words_sent), 32'(m_ws));
`ifdef FIFO_PKT_DRAIN_PARITY_EN
        chk("out_parity", 32'(out_parity), 32'(m_par));
`endif
    endtask

    typedef struct {
        logic       rd_en;
        logic       valid;
        logic [1:0] data;
        logic       sop;
        logic       eop;
        logic       bsy;
        int         ws;
    } vec_t;

    function automatic vec_t mk(input int rd, input int v, input int d, input int s,
                                input int e, input int b, input int ws);
        vec_t r;
        r.rd_en = rd[0]; r.valid = v[0]; r.data = d[1:0]; r.sop = s[0];
        r.eop = e[0]; r.bsy = b[0]; r.ws = ws;
        return r;
    endfunction

    vec_t tbl[7];

    initial begin
        tbl[0] = mk(1, 1, 0, 1, 0, 1, 0);
        tbl[1] = mk(1, 1, 1, 0, 0, 1, 1);
        tbl[2] = mk(1, 1, 2, 0, 0, 1, 2);
        tbl[3] = mk(1, 1, 3, 0, 1, 1, 3);
        tbl[4] = mk(0, 0, 3, 0, 1, 1, 4);
        tbl[5] = mk(0, 0, 3, 0, 1, 0, 4);
        tbl[6] = mk(1, 1, 0, 1, 0, 1, 4);

        reset = 1'b0; enable = 1'b1; out_ready = 1'b1; pops = 0; last_pop = 1'b0;
        for (int i = 0; i < 8; i++) q.push_back(W'(i % 4));
        drive_fifo();
        model_reset();
        #1;
        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_ws",    32'(words_sent), 32'd0);
        reset = 1'b1;

        // Preloaded 0,1,2,3,0,1,2,3 with sink always ready
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 1'b1);
            chk("tbl_rd_en", 32'(last_pop),   32'(tbl[i].rd_en));
            chk("tbl_valid", 32'(out_valid),  32'(tbl[i].valid));
            chk("tbl_data",  32'(out_data),   32'(tbl[i].data));
            chk("tbl_sop",   32'(out_sop),    32'(tbl[i].sop));
            chk("tbl_eop",   32'(out_eop),    32'(tbl[i].eop));
            chk("tbl_busy",  32'(busy),       32'(tbl[i].bsy));
            chk("tbl_ws",    32'(words_sent), 32'(tbl[i].ws));
        end
        repeat (8) step(1'b1, 1'b1);

        // Stall after the first word: data and sop must hold, no pops
        for (int i = 0; i < 4; i++) q.push_back(W'(i));
        step(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0);
            chk("stall_pop",  32'(last_pop), 32'd0);
            chk("stall_data", 32'(out_data), 32'd0);
            chk("stall_sop",  32'(out_sop),  32'd1);
        end
        repeat (8) step(1'b1, 1'b1);

        // enable low: no packet starts
        for (int i = 0; i < 8; i++) q.push_back(W'(3 - (i % 4)));
        repeat (4) begin
            step(1'b0, 1'b1);
            chk("en0_pop",  32'(last_pop), 32'd0);
            chk("en0_busy", 32'(busy), 32'd0);
        end
        // enable dropped after the 2nd pop: packet still completes
        pops = 0;
        repeat (2) step(1'b1, 1'b1);
        repeat (10) step(1'b0, 1'b1);
        chk("en_drop_pops", 32'(pops), 32'd4);

        // Async reset after 2 words of a packet
        repeat (2) step(1'b1, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_data",  32'(out_data), 32'd0);
        chk("arst_sop",   32'(out_sop), 32'd0);
        chk("arst_eop",   32'(out_eop), 32'd0);
        chk("arst_ws",    32'(words_sent), 32'd0);
        chk("arst_busy",  32'(busy), 32'd0);
        chk("arst_rd_en", 32'(fifo_rd_en), 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        step(1'b1, 1'b1);
        chk("post_rst_sop", 32'(out_sop), 32'd1);
        chk("post_rst_ws",  32'(words_sent), 32'd0);

        // Randomized traffic, starvation and back-pressure
        for (int c = 0; c < 2000; c++) begin
            if (((c / 100) % 3 != 2) && q.size() < 12 && $urandom_range(0, 1) == 1)
                q.push_back(W'($urandom));
            step(($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
